sample_hold_multi: RTL and testbench
====================================

# sample_hold_multi

Multi-channel, mode-selectable windowed sample-and-hold for the monitoring and diagnostics paths. It divides the stream into windows of a runtime-programmable length that realign on `sync`. Per channel, it reduces each window to one value: first sample, maximum, minimum or saturating sum. It publishes that value on a held output with a one-cycle valid strobe. Typical placement is between a channelised datapath and slow readout logic (software registers, snapshot blocks).

## Interface
- `WIDTH`, 8, per-channel data width in bits, unsigned.
- `CHANNELS`, 4, number of parallel channels sharing one window counter.
- `PERIOD_BITS`, 7, width of the window counter and of `period_m1`; maximum window is 2^PERIOD_BITS clocks.

- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `sync`  in  1  window realignment pulse.
- `period_m1`  in  PERIOD_BITS  window length minus one.
- `mode`  in  2  reduction mode: 0 = first sample, 1 = max, 2 = min, 3 = saturating sum.
- `din`  in  CHANNELS*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH].
- `dout`  out  CHANNELS*WIDTH  held per-channel result, same packing as `din`.
- `dout_valid`  out  1  one-cycle strobe; `dout` changed on this cycle.
- `sync_out`  out  1  high together with the first `dout_valid` after a `sync`.

## Operation
- Reset (`rst_n` = 0 at an edge) has the following effect:
  - `ctr` is cleared to 0.
  - All per-channel accumulators are cleared.
  - `dout`, `dout_valid` and `sync_out` are driven to 0.
  - An internal `sync_pend` flag is cleared.
  - `period_q` and `mode_q` are loaded from `period_m1` and `mode`.
- Window counter `ctr` advances by 1 each cycle. It returns to 0 in three cases:
  - on `sync`;
  - when `ctr == period_q`, the terminal cycle;
  - on reset.
- `period_q` and `mode_q` reload from their inputs on every edge at which `ctr` returns to 0. Changes to `period_m1` or `mode` mid-window have no effect until the next window.
- A window is the cycles with `ctr` = 0 .. `period_q`, which is `period_q`+1 samples. A window always starts on the first cycle after a reset release, a `sync` or a terminal cycle.
- Per-channel accumulator `acc[c]`, WIDTH bits:
  - On the `ctr == 0` cycle, `acc[c]` takes `din[c]` in every mode.
  - On later cycles, mode 0 holds the value.
  - Mode 1 takes max(`acc`, `din`).
  - Mode 2 takes min(`acc`, `din`).
  - Mode 3 takes `acc` + `din`, computed in WIDTH+1 bits and clamped to 2^WIDTH−1 on overflow.
- Publication happens on the terminal cycle (`ctr == period_q`):
  - Each channel's reduction, including that cycle's `din`, is registered into `dout`.
  - `dout_valid` is set for one cycle.
- Between publications, `dout` holds its value.
- `sync` with `ctr < period_q` aborts the window:
  - There is no publication.
  - `dout` holds.
  - The `sync` cycle's `din` is discarded.
  - `sync_pend` is set.
- `sync` on the terminal cycle completes the window (it publishes) and still restarts the counter and sets `sync_pend`.
- `sync_out` = `sync_pend` gated with the publish strobe. `sync_pend` clears on that publication.
- `period_m1` = 0 gives a one-sample window: every cycle publishes the previous cycle's `din` in all modes.

## Timing
- Latency: the last sample of a window appears on `dout` one clock after it is presented on `din`. `dout_valid` is high in that same cycle.
- Steady-state publication rate is one per `period_q`+1 clocks. No back-pressure: a downstream consumer must take each strobe.
- The first publication after reset release is `period_m1`+1 clocks after the first released edge.
- After a `sync` at cycle t, the first `dout_valid` and `sync_out` are at cycle t+`period_q'`+2, where `period_q'` is the value loaded at the `sync` edge.
- Reset mid-window discards the window. No strobe is issued until a full window elapses after release.
- `rst_n` overrides `sync`. A `sync` while `rst_n` = 0 is ignored and does not set `sync_pend`.

## Test plan
- WIDTH=8, CHANNELS=4, mode 0, `period_m1`=3, `din` = ramp (ch c = 4n+c): after reset, `dout_valid` fires every 4 clocks. Each result equals the window's first sample (first result ch0=0, ch1=1, …).
- Mode 1 then mode 2, `period_m1`=7, ch0 = 10,200,3,255,0,9,9,9: max publishes 255 and min publishes 0, each one clock after the 8th sample. Other channels reduce independently.
- Mode 3, `period_m1`=3, `din`=100 on all channels: published sum is 255 (saturated). With `din`=60 the sum is 240.
- `sync` at `ctr`=2 of a `period_m1`=7 window: no strobe, `dout` unchanged. The next `dout_valid` and `sync_out` are 9 clocks after the `sync`. The sample on the `sync` cycle is excluded.
- Change `period_m1` from 7 to 1 and `mode` from 0 to 1 mid-window: the current window still runs 8 clocks in mode 0. Subsequent windows are 2 clocks in max mode.
- `period_m1`=0, `sync` on the terminal cycle, and `rst_n` low for 1 clock mid-stream: every-cycle publication with `sync_out` on the next strobe. Reset forces all outputs to 0 and suppresses strobes until one full window after release.

Source files
------------

// File: rtl/sample_hold_multi.sv
// Windowed multi-channel sample-and-hold: each channel reduces a window to one value
// (first/max/min/saturating sum) and publishes it on a held output with a valid strobe.

module sample_hold_lane #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             first_i,   // ctr == 0: window's opening sample
    input  logic             upd_i,     // low on an aborting sync, sample discarded
    input  logic             pub_i,     // terminal cycle
    input  logic [1:0]       mode_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o
);

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [WIDTH-1:0] red;
    logic [WIDTH:0]   sum;

    always_comb begin
        sum = {1'b0, acc_q} + {1'b0, din_i};
        red = acc_q;
        if (first_i) begin
            red = din_i;
        end else begin
            case (mode_i)
                2'd0:    red = acc_q;
                2'd1:    red = (din_i > acc_q) ? din_i : acc_q;
                2'd2:    red = (din_i < acc_q) ? din_i : acc_q;
                2'd3:    red = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
                default: red = acc_q;
            endcase
        end
        acc_d  = upd_i ? red : acc_q;
        // Publication includes the terminal cycle's own sample.
        dout_d = pub_i ? red : dout_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q  <= '0;
            dout_q <= '0;
        end else begin
            acc_q  <= acc_d;
            dout_q <= dout_d;
        end
    end

    assign dout_o = dout_q;

endmodule

module sample_hold_multi #(
    parameter int WIDTH       = 8,
    parameter int CHANNELS    = 4,
    parameter int PERIOD_BITS = 7
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      sync,
    input  logic [PERIOD_BITS-1:0]    period_m1,
    input  logic [1:0]                mode,
    input  logic [CHANNELS*WIDTH-1:0] din,
    output logic [CHANNELS*WIDTH-1:0] dout,
    output logic                      dout_valid,
    output logic                      sync_out
);

    logic [PERIOD_BITS-1:0] ctr_q, ctr_d;
    logic [PERIOD_BITS-1:0] period_q, period_d;
    logic [1:0]             mode_q, mode_d;
    logic                   sync_pend_q, sync_pend_d;
    logic                   dout_valid_q, dout_valid_d;
    logic                   sync_out_q, sync_out_d;
    logic                   term, restart, first, upd;

    logic [CHANNELS-1:0][WIDTH-1:0] din_lane;
    logic [CHANNELS-1:0][WIDTH-1:0] dout_lane;

    always_comb begin
        term    = (ctr_q == period_q);
        restart = sync | term;
        first   = (ctr_q == '0);
        upd     = ~(sync & ~term);
        ctr_d   = restart ? '0 : ctr_q + PERIOD_BITS'(1);
        // Window configuration is only sampled at window boundaries.
        period_d     = restart ? period_m1 : period_q;
        mode_d       = restart ? mode : mode_q;
        dout_valid_d = term;
        sync_out_d   = term & sync_pend_q;
        // A sync on the terminal cycle re-arms the flag for the following window.
        sync_pend_d  = term ? sync : (sync_pend_q | sync);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctr_q        <= '0;
            period_q     <= period_m1;
            mode_q       <= mode;
            sync_pend_q  <= 1'b0;
            dout_valid_q <= 1'b0;
            sync_out_q   <= 1'b0;
        end else begin
            ctr_q        <= ctr_d;
            period_q     <= period_d;
            mode_q       <= mode_d;
            sync_pend_q  <= sync_pend_d;
            dout_valid_q <= dout_valid_d;
            sync_out_q   <= sync_out_d;
        end
    end

    assign din_lane = din;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
        sample_hold_lane #(.WIDTH(WIDTH)) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .first_i (first),
            .upd_i   (upd),
            .pub_i   (term),
            .mode_i  (mode_q),
            .din_i   (din_lane[g]),
            .dout_o  (dout_lane[g])
        );
    end

    assign dout       = dout_lane;
    assign dout_valid = dout_valid_q;
    assign sync_out   = sync_out_q;

endmodule

// File: tb/tb_sample_hold_multi.sv
// Directed bench for sample_hold_multi: hand-computed windows across all modes,
// sync abort/terminal cases, mid-window reconfiguration and mid-stream reset.

module tb_sample_hold_multi;

    logic        clk;
    logic        rst_n;
    logic        sync;
    logic [6:0]  period_m1;
    logic [1:0]  mode;
    logic [31:0] din;
    logic [31:0] dout;
    logic        dout_valid;
    logic        sync_out;

    int checks;
    int errors;

    logic [7:0]  a0 [8];
    logic [31:0] exp_d;

    sample_hold_multi #(.WIDTH(8), .CHANNELS(4), .PERIOD_BITS(7)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sync       (sync),
        .period_m1  (period_m1),
        .mode       (mode),
        .din        (din),
        .dout       (dout),
        .dout_valid (dout_valid),
        .sync_out   (sync_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rep(input logic [7:0] x);
        return {4{x}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step(input string tag, input logic v, input logic so, input logic [31:0] d);
        tick();
        chk({tag, "_valid"}, {31'b0, dout_valid}, {31'b0, v});
        chk({tag, "_sync_out"}, {31'b0, sync_out}, {31'b0, so});
        chk({tag, "_dout"}, dout, d);
    endtask

    task automatic do_reset(input logic [1:0] m, input logic [6:0] p);
        rst_n = 1'b0; sync = 1'b0; mode = m; period_m1 = p; din = 32'h0;
        tick();
        chk("rst_valid", {31'b0, dout_valid}, 32'h0);
        chk("rst_sync_out", {31'b0, sync_out}, 32'h0);
        chk("rst_dout", dout, 32'h0);
        rst_n = 1'b1;
    endtask

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b0; sync = 1'b0; period_m1 = 7'd3; mode = 2'd0; din = 32'h0;
        a0[0] = 8'd10; a0[1] = 8'd200; a0[2] = 8'd3; a0[3] = 8'd255;
        a0[4] = 8'd0;  a0[5] = 8'd9;   a0[6] = 8'd9; a0[7] = 8'd9;
        tick();

        // Mode 0, 4-sample windows, ramp data: each result is the window's first sample.
        do_reset(2'd0, 7'd3);
        exp_d = 32'h0;
        for (int k = 0; k < 12; k++) begin
            din = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
            if (k % 4 == 3) exp_d = {8'(4*(k-3)+3), 8'(4*(k-3)+2), 8'(4*(k-3)+1), 8'(4*(k-3))};
            step("ramp", (k % 4 == 3), 1'b0, exp_d);
        end

        // Max window, then min window (mode input picked up at the terminal edge).
        do_reset(2'd1, 7'd7);
        mode = 2'd2;
        exp_d = 32'h0;
        for (int w = 0; w < 2; w++) begin
            for (int k = 0; k < 8; k++) begin
                din = {8'd77, 8'(100 - 10*k), 8'(k+1), a0[k]};
                if (k == 7) exp_d = (w == 0) ? {8'd77, 8'd100, 8'd8, 8'd255}
                                             : {8'd77, 8'd30, 8'd1, 8'd0};
                step(w == 0 ? "max" : "min", (k == 7), 1'b0, exp_d);
            end
        end

        // Saturating sum: 4x100 clamps to 255, 4x60 = 240.
        do_reset(2'd3, 7'd3);
        exp_d = 32'h0;
        for (int k = 0; k < 8; k++) begin
            din = (k < 4) ? rep(8'd100) : rep(8'd60);
            if (k == 3) exp_d = rep(8'd255);
            if (k == 7) exp_d = rep(8'd240);
            step("sum", (k % 4 == 3), 1'b0, exp_d);
        end

        // Sync abort at ctr=2 in max mode; sync-cycle sample of 250 must be excluded.
        do_reset(2'd1, 7'd7);
        exp_d = 32'h0;
        for (int k = 0; k < 8; k++) begin
            din = rep(8'd5);
            if (k == 7) exp_d = rep(8'd5);
            step("pre", (k == 7), 1'b0, exp_d);
        end
        din = rep(8'd10);  step("abort0", 1'b0, 1'b0, exp_d);
        din = rep(8'd20);  step("abort1", 1'b0, 1'b0, exp_d);
        din = rep(8'd250); sync = 1'b1;
        step("abort_sync", 1'b0, 1'b0, exp_d);
        sync = 1'b0;
        for (int k = 0; k < 8; k++) begin
            din = (k == 4) ? rep(8'd40) : rep(8'd30);
            if (k == 7) exp_d = rep(8'd40);
            step("post_sync", (k == 7), (k == 7), exp_d);
        end
        for (int k = 0; k < 8; k++) begin
            din = rep(8'd1);
            if (k == 7) exp_d = rep(8'd1);
            step("pend_clr", (k == 7), 1'b0, exp_d);
        end

        // Mid-window reconfiguration takes effect only at the next window.
        do_reset(2'd0, 7'd7);
        exp_d = 32'h0;
        for (int k = 0; k < 8; k++) begin
            din = rep(8'(11 + k));
            if (k == 3) begin period_m1 = 7'd1; mode = 2'd1; end
            if (k == 7) exp_d = rep(8'd11);
            step("reconf", (k == 7), 1'b0, exp_d);
        end
        din = {8'd0, 8'd200, 8'd9, 8'd3};   step("max2a", 1'b0, 1'b0, exp_d);
        din = {8'd255, 8'd100, 8'd3, 8'd9}; exp_d = {8'd255, 8'd200, 8'd9, 8'd9};
        step("max2b", 1'b1, 1'b0, exp_d);
        din = rep(8'd8);                    step("max2c", 1'b0, 1'b0, exp_d);
        din = rep(8'd2);   exp_d = rep(8'd8);
        step("max2d", 1'b1, 1'b0, exp_d);

        // One-sample windows, sync on a terminal cycle, then a reset pulse mid-stream.
        do_reset(2'd0, 7'd0);
        for (int k = 0; k < 5; k++) begin
            din = rep(8'(k + 1));
            sync = (k == 2);
            step("p0", 1'b1, (k == 3), rep(8'(k + 1)));
        end
        sync = 1'b1; rst_n = 1'b0; period_m1 = 7'd3; din = rep(8'h77);
        tick();
        chk("midrst_valid", {31'b0, dout_valid}, 32'h0);
        chk("midrst_sync_out", {31'b0, sync_out}, 32'h0);
        chk("midrst_dout", dout, 32'h0);
        rst_n = 1'b1; sync = 1'b0;
        exp_d = 32'h0;
        for (int k = 0; k < 4; k++) begin
            din = rep(8'(8'h10 + k));
            if (k == 3) exp_d = rep(8'h10);
            step("after_rst", (k == 3), 1'b0, exp_d);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
